// File: rtl/fire_alert_pkg.sv
// rtl/fire_alert_pkg.sv - state encoding and default timing for fire_alert_confirm
`timescale 1ns/1ps
package fire_alert_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CONFIRM  = 2'd1,
      ST_ACTIVE   = 2'd2,
      ST_COOLDOWN = 2'd3
   } fire_state_e;

   localparam int DEF_CONFIRM_CYCLES  = 16;
   localparam int DEF_MIN_HOLD_CYCLES = 64;
   localparam int DEF_COOLDOWN_CYCLES = 32;
   localparam int DEF_CNT_W           = 16;

   // Largest of three timing parameters; sizes the shared counters.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ack_sync_edge.sv
// rtl/ack_sync_edge.sv - 2-flop synchroniser with rising-edge pulse for the ESP32 ack
`timescale 1ns/1ps
module ack_sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic async_i,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic sync_dly_q;

   // Two flops for metastability, a third holds the previous synchronised level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q     <= 1'b0;
         sync_q     <= 1'b0;
         sync_dly_q <= 1'b0;
      end else begin
         meta_q     <= async_i;
         sync_q     <= meta_q;
         sync_dly_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~sync_dly_q;

endmodule

// File: rtl/fire_alert_confirm.sv
// rtl/fire_alert_confirm.sv - fire alarm confirm/hold/cooldown FSM; FIRE_EVENT_CNT_EN adds event_count
`timescale 1ns/1ps
module fire_alert_confirm
   import fire_alert_pkg::*;
#(
`ifdef FIRE_EVENT_CNT_EN
   parameter int CNT_W           = DEF_CNT_W,
`endif
   parameter int CONFIRM_CYCLES  = DEF_CONFIRM_CYCLES,
   parameter int MIN_HOLD_CYCLES = DEF_MIN_HOLD_CYCLES,
   parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic alert_in,
   input  logic ack_in,
   output logic alert_out,
   output logic alert_irq,
   output logic busy
`ifdef FIRE_EVENT_CNT_EN
   ,
   output logic [CNT_W-1:0] event_count
`endif
);

   localparam int CW = $clog2(max3(CONFIRM_CYCLES, MIN_HOLD_CYCLES, COOLDOWN_CYCLES)) + 1;
   localparam logic [CW-1:0] CONF_LAST = CW'(CONFIRM_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_HOLD_CYCLES - 1);
   localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   fire_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] hold_q, hold_d;
   logic          ack_seen_q, ack_seen_d;
   logic          ack_rise;
   logic          alert_out_q, alert_irq_q, busy_q;
   logic          irq_d;

   ack_sync_edge u_ack_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i (ack_in),
      .rise_o  (ack_rise)
   );

   // Next-state logic; cnt is shared by CONFIRM and COOLDOWN, hold/ack only live in ACTIVE.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hold_d     = '0;
      ack_seen_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (alert_in) begin
               if (CONFIRM_CYCLES == 1) begin
                  state_d = ST_ACTIVE;
               end else begin
                  state_d = ST_CONFIRM;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         ST_CONFIRM: begin
            if (!alert_in) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CONF_LAST) begin
               state_d = ST_ACTIVE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_ACTIVE: begin
            hold_d     = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
            ack_seen_d = ack_seen_q | ack_rise;
            if ((hold_q == HOLD_LAST) && ack_seen_q && !alert_in) begin
               state_d    = ST_COOLDOWN;
               cnt_d      = '0;
               hold_d     = '0;
               ack_seen_d = 1'b0;
            end
         end
         ST_COOLDOWN: begin
            if (cnt_q == COOL_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign irq_d = (state_d == ST_ACTIVE) && (state_q != ST_ACTIVE);

   // State, counters and outputs; outputs follow the next state so they line up with it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         hold_q      <= '0;
         ack_seen_q  <= 1'b0;
         alert_out_q <= 1'b0;
         alert_irq_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         ack_seen_q  <= ack_seen_d;
         alert_out_q <= (state_d == ST_ACTIVE);
         alert_irq_q <= irq_d;
         busy_q      <= (state_d != ST_IDLE);
      end
   end

   assign alert_out = alert_out_q;
   assign alert_irq = alert_irq_q;
   assign busy      = busy_q;

`ifdef FIRE_EVENT_CNT_EN
   logic [CNT_W-1:0] event_cnt_q;

   // Counts alarm assertions, sticking at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         event_cnt_q <= '0;
      end else if (irq_d && (event_cnt_q != '1)) begin
         event_cnt_q <= event_cnt_q + 1'b1;
      end
   end

   assign event_count = event_cnt_q;
`endif

endmodule

// File: tb/tb_fire_alert_confirm.sv
// tb/tb_fire_alert_confirm.sv - directed self-checking bench for fire_alert_confirm
`timescale 1ns/1ps
module tb_fire_alert_confirm;

   logic clk;
   logic reset_n;
   logic alert_in;
   logic ack_in;
   logic alert_out;
   logic alert_irq;
   logic busy;
`ifdef FIRE_EVENT_CNT_EN
   logic [15:0] event_count;
`endif

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fire_alert_confirm dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .alert_in  (alert_in),
      .ack_in    (ack_in),
      .alert_out (alert_out),
      .alert_irq (alert_irq),
      .busy      (busy)
`ifdef FIRE_EVENT_CNT_EN
      ,
      .event_count (event_count)
`endif
   );

   // One clock edge, then settle 1 ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      alert_in = 1'b0;
      ack_in   = 1'b0;
      #12;
      checks++;
      if (alert_out !== 1'b0) begin errors++; $display("FAIL reset_alert_out: got %b want 0", alert_out); end
      checks++;
      if (alert_irq !== 1'b0) begin errors++; $display("FAIL reset_alert_irq: got %b want 0", alert_irq); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      tick();
      reset_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || alert_out !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset: busy=%b alert_out=%b want 0 0", busy, alert_out);
      end
   endtask

   // 15 high samples then a low one: no alarm, back to idle.
   task automatic test_abort();
      int bad = 0;
      alert_in = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (alert_out !== 1'b0 || alert_irq !== 1'b0 || busy !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL abort_window: %0d bad cycles want 0", bad); end
      alert_in = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_drop: got %b want 0", busy); end
      checks++;
      if (alert_out !== 1'b0 || alert_irq !== 1'b0) begin
         errors++; $display("FAIL abort_no_alarm: alert_out=%b irq=%b want 0 0", alert_out, alert_irq);
      end
      tick();
   endtask

   // Continuous alert: alarm after edge 15, irq on that cycle.
   task automatic test_confirm();
      int bad = 0;
      alert_in = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL confirm_busy_edge0: got %b want 1", busy); end
      for (int i = 1; i < 15; i++) begin
         tick();
         if (alert_out !== 1'b0 || alert_irq !== 1'b0 || busy !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL confirm_window: %0d bad cycles want 0", bad); end
      tick();
      checks++;
      if (alert_out !== 1'b1) begin errors++; $display("FAIL confirm_alert_out_edge15: got %b want 1", alert_out); end
      checks++;
      if (alert_irq !== 1'b1) begin errors++; $display("FAIL confirm_irq_edge15: got %b want 1", alert_irq); end
   endtask

   // Ack at cycle 10, alert low at 20: alarm lasts exactly 64 cycles, cooldown 32.
   task automatic test_hold_release();
      int hi = 1, fall = -1, idle = -1, irq_cnt = 0, relapse = 0;
      for (int c = 0; c < 100; c++) begin
         if (c == 10) ack_in = 1'b1;
         if (c == 13) ack_in = 1'b0;
         if (c == 20) alert_in = 1'b0;
         tick();
         if (alert_irq === 1'b1) irq_cnt++;
         if (fall < 0) begin
            if (alert_out === 1'b1) hi++;
            else fall = c + 1;
         end else if (alert_out !== 1'b0) begin
            relapse++;
         end
         if (busy === 1'b0 && idle < 0) idle = c + 1;
      end
      checks++;
      if (hi != 64) begin errors++; $display("FAIL hold_high_cycles: got %0d want 64", hi); end
      checks++;
      if (fall != 64) begin errors++; $display("FAIL hold_fall_cycle: got %0d want 64", fall); end
      checks++;
      if (irq_cnt != 0) begin errors++; $display("FAIL irq_single_cycle: extra pulses %0d want 0", irq_cnt); end
      checks++;
      if (idle != 96) begin errors++; $display("FAIL cooldown_idle_cycle: got %0d want 96", idle); end
      checks++;
      if (relapse != 0) begin errors++; $display("FAIL hold_relapse: got %0d want 0", relapse); end
   endtask

   // Ack while alert still high; re-assert during cooldown.
   task automatic test_ack_while_alert();
      int fall = -1, idle = -1, irq2 = -1, stray = 0;
      logic busy_after_idle = 1'b0;
      alert_in = 1'b1;
      for (int i = 0; i < 16; i++) tick();
      checks++;
      if (alert_irq !== 1'b1 || alert_out !== 1'b1) begin
         errors++; $display("FAIL ack_case_entry: irq=%b alert_out=%b want 1 1", alert_irq, alert_out);
      end
      for (int c = 0; c < 160; c++) begin
         if (c == 10) ack_in = 1'b1;
         if (c == 13) ack_in = 1'b0;
         if (c == 100) alert_in = 1'b0;
         if (c == 105) alert_in = 1'b1;
         tick();
         if (fall < 0 && alert_out === 1'b0) fall = c + 1;
         else if (fall >= 0 && irq2 < 0) begin
            if (alert_irq === 1'b1) irq2 = c + 1;
            else if (alert_out !== 1'b0) stray++;
         end
         if (idle >= 0 && c + 1 == idle + 1) busy_after_idle = busy;
         if (fall >= 0 && idle < 0 && busy === 1'b0) idle = c + 1;
      end
      checks++;
      if (fall != 101) begin errors++; $display("FAIL ack_alert_fall: got %0d want 101", fall); end
      checks++;
      if (idle != 133) begin errors++; $display("FAIL cooldown_ignore_idle: got %0d want 133", idle); end
      checks++;
      if (busy_after_idle !== 1'b1) begin errors++; $display("FAIL reconfirm_busy: got %b want 1", busy_after_idle); end
      checks++;
      if (irq2 != 149) begin errors++; $display("FAIL reconfirm_irq: got %0d want 149", irq2); end
      checks++;
      if (stray != 0) begin errors++; $display("FAIL cooldown_stray_alarm: got %0d want 0", stray); end
   endtask

   // Async reset mid-ACTIVE, ignored ack afterwards, full reconfirm.
   task automatic test_reset_mid_active();
      int bad = 0, early = 0;
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (alert_out !== 1'b0 || alert_irq !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL async_reset: out=%b irq=%b busy=%b want 0 0 0", alert_out, alert_irq, busy);
      end
      alert_in = 1'b0;
      tick();
      reset_n = 1'b1;
      ack_in  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) ack_in = 1'b0;
         tick();
         if (busy !== 1'b0 || alert_out !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL ack_after_reset: %0d bad cycles want 0", bad); end
      alert_in = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (alert_out !== 1'b0) early++;
      end
      checks++;
      if (early != 0) begin errors++; $display("FAIL reset_reconfirm_early: %0d cycles want 0", early); end
      tick();
      checks++;
      if (alert_out !== 1'b1 || alert_irq !== 1'b1) begin
         errors++; $display("FAIL reset_reconfirm: out=%b irq=%b want 1 1", alert_out, alert_irq);
      end
   endtask

`ifdef FIRE_EVENT_CNT_EN
   task automatic test_event_count();
      reset_n  = 1'b0;
      alert_in = 1'b0;
      ack_in   = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      checks++;
      if (event_count !== 16'd0) begin errors++; $display("FAIL evcnt_reset: got %0d want 0", event_count); end
      alert_in = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      alert_in = 1'b0;
      tick();
      checks++;
      if (event_count !== 16'd0) begin errors++; $display("FAIL evcnt_abort: got %0d want 0", event_count); end
      for (int k = 0; k < 3; k++) begin
         alert_in = 1'b1;
         for (int i = 0; i < 16; i++) tick();
         alert_in = 1'b0;
         ack_in   = 1'b1;
         for (int i = 0; i < 3; i++) tick();
         ack_in = 1'b0;
         for (int i = 0; i < 100; i++) tick();
      end
      checks++;
      if (event_count !== 16'd3) begin errors++; $display("FAIL evcnt_three: got %0d want 3", event_count); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL evcnt_idle: busy=%b want 0", busy); end
   endtask
`endif

   initial begin
      test_reset();
      test_abort();
      test_confirm();
      test_hold_release();
      test_ack_while_alert();
      test_reset_mid_active();
`ifdef FIRE_EVENT_CNT_EN
      test_event_count();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fire_alert_confirm.md
Name: fire_alert_confirm

Overview:
Downstream stage of the FFT/camera fusion block. Takes the fused per-cycle fire decision, requires it to persist before declaring an alarm, and drives the alarm line and interrupt pulse to the ESP32. Holds the alarm until the ESP32 acknowledges it, then enforces a cooldown before it can re-arm.

Parameters:
CONFIRM_CYCLES, 16, consecutive high samples of alert_in required to raise the alarm (>=1)
MIN_HOLD_CYCLES, 64, minimum number of cycles alert_out stays high (>=1)
COOLDOWN_CYCLES, 32, cycles alert_in is ignored after the alarm clears (>=1)
CNT_W, 16, event counter width (optional feature only)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
alert_in  input  1  fused fire decision, already synchronous to clk
ack_in  input  1  ESP32 acknowledge, asynchronous level
alert_out  output  1  confirmed alarm to ESP32, registered
alert_irq  output  1  one-cycle pulse on alarm assertion, registered
busy  output  1  high when state != IDLE, registered

Behaviour:
- Reset: state IDLE; all counters, ack synchroniser flops and ack_seen at 0; alert_out, alert_irq and busy at 0. Reset asserted mid-operation clears all outputs immediately (asynchronous). After release the block starts in IDLE.
- ack_in passes through a 2-flop synchroniser. A rising edge of the synchronised ack sets ack_seen, 3 clk edges after ack_in rises.
- State machine:
  - IDLE: if alert_in is sampled at 1, go to CONFIRM with cnt=1. If CONFIRM_CYCLES==1, go directly to ACTIVE instead.
  - CONFIRM: on alert_in=1, if cnt==CONFIRM_CYCLES-1 go to ACTIVE, else increment cnt. On alert_in=0, go to IDLE and clear cnt.
  - ACTIVE: alert_out=1. alert_irq=1 in the first ACTIVE cycle only. On entry, hold_cnt=0 and ack_seen=0. hold_cnt increments each cycle and saturates at MIN_HOLD_CYCLES-1. Exit to COOLDOWN on the first edge where all three hold: hold_cnt==MIN_HOLD_CYCLES-1, ack_seen=1, alert_in=0.
  - COOLDOWN: alert_out=0. alert_in is ignored. Count COOLDOWN_CYCLES cycles, then go to IDLE. If alert_in is still high on return, a full CONFIRM restarts.
- Timing: with alert_in high from edge 0, alert_out is first high after edge CONFIRM_CYCLES-1.
- alert_out stays high for at least MIN_HOLD_CYCLES cycles.
- An ack that arrives before the hold expires is latched and honoured once the hold expires.
- If ack is given while alert_in is still 1, the alarm stays high until alert_in drops.
- Ack edges in IDLE, CONFIRM or COOLDOWN are ignored.
- Counter width is $clog2 of the largest parameter + 1. Counters never wrap.

Optional Feature:
FIRE_EVENT_CNT_EN
- Defined: adds output port event_count [CNT_W-1:0], reset to 0. It increments on every alert_irq pulse and saturates at all-ones.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package fire_alert_pkg: 2-bit state enum (IDLE, CONFIRM, ACTIVE, COOLDOWN) and default timing constants.
- One sub-module: ack_sync_edge, which contains the 2-flop synchroniser plus rising-edge detect and outputs a one-cycle pulse.

Test Plan:
1. alert_in high for 15 cycles, then low -> alert_out and alert_irq stay 0; busy drops the cycle after alert_in drops; state returns to IDLE.
2. alert_in high continuously from edge 0 -> alert_out=1 after edge 15; alert_irq high for exactly 1 cycle; busy=1 from edge 0.
3. Alarm active; ack_in pulsed at ACTIVE cycle 10; alert_in low at ACTIVE cycle 20 -> alert_out stays high for exactly 64 cycles, then COOLDOWN.
4. Alarm active; ack given; alert_in held high to ACTIVE cycle 100 -> alert_out falls the edge after alert_in drops. Re-assert alert_in during COOLDOWN -> ignored for 32 cycles, then a new irq 16 cycles after IDLE is re-entered.
5. reset_n pulsed low mid-ACTIVE -> alert_out, alert_irq and busy go to 0 without a clock edge. A later ack has no effect; a new alarm requires a full 16-cycle confirm.
6. With FIRE_EVENT_CNT_EN defined, 3 complete alarm cycles -> event_count=3. A confirm window aborted at 15 samples does not increment the count.
